// File: rtl/ifq_pkg.sv
// ============================================================================
// Module : ifq_pkg
// Brief  : Shared constants, FSM state encoding and entry type for the
//          instruction fetch queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ifq_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int IFQ_XLEN = 64;
  localparam int IFQ_ILEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } ifq_state_t;

  typedef struct packed {
    logic [IFQ_XLEN-1:0] pc;
    logic [IFQ_ILEN-1:0] instr;
  } ifq_entry_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_queue_if.sv
// ============================================================================
// Module : instr_fetch_queue_if
// Brief  : Instruction-memory read channel (single outstanding request).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_fetch_queue_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [ILEN-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

`default_nettype wire

// File: rtl/ifq_fifo.sv
// ============================================================================
// Module : ifq_fifo
// Brief  : Circular entry store with wrap-bit pointers and combinational
//          head / head+1 read ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = ifq_entry_t
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  ENTRY_T                  push_data,
  input  logic                    pop,
  input  logic                    flush,
  output ENTRY_T                  head,
  output ENTRY_T                  head_next,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  ENTRY_T        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic [AW-1:0] rd_idx_next;

  assign count       = wr_ptr - rd_ptr;
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_idx_next = rd_ptr[AW-1:0] + AW'(1);
  assign head        = mem[rd_ptr[AW-1:0]];
  assign head_next   = mem[rd_idx_next];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && (count != '0))
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: every read is qualified by count.
  always_ff @(posedge clk) begin
    if (push && !full && !flush)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_queue.sv
// ============================================================================
// Module : instr_fetch_queue
// Brief  : Sequential instruction fetcher with a small PC-tagged queue feeding
//          decode; honours decode stall and branch/jump redirect.
//          Define IFQ_STATS_EN to add saturating stall/empty/flush counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  instr_fetch_queue_if.master     imem,
  input  logic                    f_to_d_enable,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic [ILEN-1:0]         instruction,
  output logic [XLEN-1:0]         instruction_pc,
  output logic                    instruction_valid,
  output logic [ILEN-1:0]         next_instruction,
  output logic                    next_valid,
  output logic [$clog2(DEPTH):0]  queue_count
`ifdef IFQ_STATS_EN
 ,output logic [31:0]             stat_stall_cycles,
  output logic [31:0]             stat_empty_cycles,
  output logic [15:0]             stat_flushes
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  ifq_state_t      state;
  logic [XLEN-1:0] fetch_pc;
  logic            req_r;
  logic [XLEN-1:0] addr_r;
  entry_t          head;
  entry_t          head_next;
  entry_t          push_data;
  logic            do_push;
  logic            do_pop;
  logic [CW-1:0]   count_after;
  logic            can_issue;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] fetch_pc_inc;

  assign redirect_tgt = redirect_pc & ~XLEN'(3);
  assign fetch_pc_inc = fetch_pc + XLEN'(4);

  // Redirect discards this cycle's push and pop.
  assign do_push     = (state == REQ) && imem.ack && !redirect_valid;
  assign do_pop      = f_to_d_enable && instruction_valid && !redirect_valid;
  assign count_after = queue_count + CW'(do_push) - CW'(do_pop);
  assign can_issue   = count_after < CW'(DEPTH);

  assign push_data.pc    = fetch_pc;
  assign push_data.instr = imem.rdata;

  ifq_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (do_push),
    .push_data (push_data),
    .pop       (do_pop),
    .flush     (redirect_valid),
    .head      (head),
    .head_next (head_next),
    .count     (queue_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_r    <= 1'b0;
      addr_r   <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_tgt;
          end else if (can_issue) begin
            req_r  <= 1'b1;
            addr_r <= fetch_pc;
            state  <= REQ;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_tgt;
            if (imem.ack) begin
              req_r <= 1'b0;
              state <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (imem.ack) begin
            fetch_pc <= fetch_pc_inc;
            if (can_issue) begin
              addr_r <= fetch_pc_inc;
            end else begin
              req_r <= 1'b0;
              state <= IDLE;
            end
          end
        end
        DRAIN: begin
          // Stale request stays on the bus until memory answers it.
          if (redirect_valid)
            fetch_pc <= redirect_tgt;
          if (imem.ack) begin
            req_r <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          req_r <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign imem.req  = req_r;
  assign imem.addr = addr_r;

  assign instruction_valid = (queue_count != '0);
  assign next_valid        = (queue_count >= CW'(2));
  assign instruction       = instruction_valid ? head.instr : ILEN'(NOP_INSTR);
  assign instruction_pc    = instruction_valid ? head.pc : '0;
  assign next_instruction  = next_valid ? head_next.instr : ILEN'(NOP_INSTR);

`ifdef IFQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_cycles <= '0;
      stat_empty_cycles <= '0;
      stat_flushes      <= '0;
    end else begin
      if (instruction_valid && !f_to_d_enable && (stat_stall_cycles != '1))
        stat_stall_cycles <= stat_stall_cycles + 1'b1;
      if (!instruction_valid && !redirect_valid && (stat_empty_cycles != '1))
        stat_empty_cycles <= stat_empty_cycles + 1'b1;
      if (redirect_valid && (stat_flushes != '1))
        stat_flushes <= stat_flushes + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
// ============================================================================
// Module : tb_instr_fetch_queue
// Brief  : Directed scoreboard bench for instr_fetch_queue with a budgeted
//          instruction-memory responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_queue;
  import ifq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_to_d_enable;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] instruction;
  logic [63:0] instruction_pc;
  logic        instruction_valid;
  logic [31:0] next_instruction;
  logic        next_valid;
  logic [2:0]  queue_count;
`ifdef IFQ_STATS_EN
  logic [31:0] stat_stall_cycles;
  logic [31:0] stat_empty_cycles;
  logic [15:0] stat_flushes;
`endif

  always #5 clk = ~clk;

  instr_fetch_queue_if #(.XLEN(64), .ILEN(32)) imem();

  instr_fetch_queue dut (
    .clk               (clk),
    .rst               (rst),
    .imem              (imem),
    .f_to_d_enable     (f_to_d_enable),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .instruction       (instruction),
    .instruction_pc    (instruction_pc),
    .instruction_valid (instruction_valid),
    .next_instruction  (next_instruction),
    .next_valid        (next_valid),
    .queue_count       (queue_count)
`ifdef IFQ_STATS_EN
   ,.stat_stall_cycles (stat_stall_cycles),
    .stat_empty_cycles (stat_empty_cycles),
    .stat_flushes      (stat_flushes)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          mem_budget = 0;
  int          mem_delay  = 0;
  int          wait_cnt   = 0;

  // Contents of the bench's instruction memory.
  function automatic logic [31:0] word_at(input logic [63:0] pc);
    return 32'hC0DE_0000 ^ pc[31:0];
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input int budget, input int delay);
    mem_budget = budget;
    mem_delay  = delay;
    wait_cnt   = 0;
  endtask

  task automatic push_seq(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back(base + 64'(4 * i));
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!instruction_valid && exp_q.size() == 0) break;
    end
    check64({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    check64({name, "_count"}, 64'(queue_count), 64'd0);
  endtask

  // Memory responder: acks after mem_delay waiting cycles, only while budget lasts.
  initial begin
    imem.ack   = 1'b0;
    imem.rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst || !imem.req) begin
        imem.ack = 1'b0;
        wait_cnt = 0;
      end else if (wait_cnt >= mem_delay && mem_budget > 0) begin
        imem.ack   = 1'b1;
        imem.rdata = word_at(imem.addr);
        mem_budget--;
        wait_cnt = 0;
      end else begin
        imem.ack = 1'b0;
        wait_cnt++;
      end
    end
  end

  // Monitor: every accepted head must match the next expected PC.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!instruction_valid) begin
          check64("empty_instr", 64'(instruction), 64'(NOP_INSTR));
          check64("empty_pc", instruction_pc, 64'd0);
        end
        if (next_valid)
          check64("next_instr", 64'(next_instruction), 64'(word_at(instruction_pc + 64'd4)));
        else
          check64("next_nop", 64'(next_instruction), 64'(NOP_INSTR));
        if (instruction_valid && f_to_d_enable && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got pc 0x%0h expected none", instruction_pc);
          end else begin
            e = exp_q.pop_front();
            check64("head_pc", instruction_pc, e);
            check64("head_instr", 64'(instruction), 64'(word_at(e)));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    f_to_d_enable  = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    @(negedge clk);
    @(negedge clk);
    check64("rst_req", 64'(imem.req), 64'd0);
    check64("rst_addr", imem.addr, 64'd0);
    check64("rst_count", 64'(queue_count), 64'd0);
    check64("rst_valid", 64'(instruction_valid), 64'd0);
    check64("rst_next_valid", 64'(next_valid), 64'd0);
    check64("rst_instr", 64'(instruction), 64'(NOP_INSTR));

    // Zero-latency memory, decode always ready: 0,4,8,C back to back.
    step();
    rst = 1'b0;
    f_to_d_enable = 1'b1;
    set_mem(4, 0);
    push_seq(64'h0, 4);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (imem.ack) begin
          seen = 1'b1;
          break;
        end
      end
      check64("first_ack_seen", 64'(seen), 64'd1);
      check64("first_ack_addr", imem.addr, 64'd0);
      check64("pre_push_valid", 64'(instruction_valid), 64'd0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check64("stream_valid", 64'(instruction_valid), 64'd1);
      check64("stream_pc", instruction_pc, 64'(4 * i));
    end
    wait_drain("seq");

    // Ack delayed three cycles: address held, queue empty meanwhile.
    check64("pend_req", 64'(imem.req), 64'd1);
    step();
    set_mem(2, 3);
    push_seq(64'h10, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check64("delay_no_ack", 64'(imem.ack), 64'd0);
      check64("delay_addr", imem.addr, 64'h10);
      check64("delay_valid", 64'(instruction_valid), 64'd0);
    end
    @(negedge clk);
    check64("delay_ack", 64'(imem.ack), 64'd1);
    wait_drain("delay");

    // Redirect while a request is outstanding and two entries are queued.
    step();
    f_to_d_enable = 1'b0;
    set_mem(2, 0);
    repeat (4) @(negedge clk);
    check64("pre_redir_count", 64'(queue_count), 64'd2);
    check64("pre_redir_addr", imem.addr, 64'h20);
    check64("pre_redir_head", instruction_pc, 64'h18);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h103;
    set_mem(1, 2);
    @(negedge clk);
    check64("redir_unacked", 64'(imem.ack), 64'd0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check64("redir_count", 64'(queue_count), 64'd0);
    check64("drain_req", 64'(imem.req), 64'd1);
    check64("drain_addr", imem.addr, 64'h20);
    push_seq(64'h100, 8);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem.req && imem.addr != 64'h20) break;
    end
    check64("refetch_req", 64'(imem.req), 64'd1);
    check64("refetch_addr", imem.addr, 64'h100);

    // Decode stall: queue fills to DEPTH and fetch stops.
    step();
    set_mem(8, 0);
    repeat (10) @(negedge clk);
    check64("full_count", 64'(queue_count), 64'd4);
    check64("full_req", 64'(imem.req), 64'd0);
    check64("full_head", instruction_pc, 64'h100);
`ifdef IFQ_STATS_EN
    begin
      logic [31:0] s0;
      s0 = stat_stall_cycles;
      repeat (5) @(negedge clk);
      check64("stat_stall_delta", 64'(stat_stall_cycles - s0), 64'd5);
    end
`endif
    step();
    f_to_d_enable = 1'b1;
    wait_drain("stall");

    // Redirect coinciding with an ack and a pop.
    step();
    f_to_d_enable = 1'b0;
    set_mem(2, 0);
    repeat (4) @(negedge clk);
    check64("coin_count", 64'(queue_count), 64'd2);
    check64("coin_addr", imem.addr, 64'h128);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    f_to_d_enable  = 1'b1;
    set_mem(1, 0);
    push_seq(64'h200, 3);
    @(negedge clk);
    check64("coin_ack", 64'(imem.ack), 64'd1);
    check64("coin_valid", 64'(instruction_valid), 64'd1);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check64("coin_flush_count", 64'(queue_count), 64'd0);
    check64("coin_idle_req", 64'(imem.req), 64'd0);
    @(negedge clk);
    check64("coin_new_req", 64'(imem.req), 64'd1);
    check64("coin_new_addr", imem.addr, 64'h200);
    step();
    set_mem(3, 0);
    wait_drain("coin");

`ifdef IFQ_STATS_EN
    check64("stat_flushes", 64'(stat_flushes), 64'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
